seq_multiplier: RTL



---
 rtl/mult_pkg.sv | 12 +
 rtl/twos_negate.sv | 11 +
 rtl/seq_multiplier.sv | 88 ++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/twos_negate.sv
// Combinational two's-complement negation of a W-bit value.
module twos_negate #(
  parameter int W = 8
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = ~din + W'(1);

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier with start/done handshake and signed/unsigned modes.
// Operands are reduced to magnitudes on load; the sign is reapplied to the final product.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sign_mode,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a, b, acc;
  logic [CNT_W-1:0]   counter;
  logic               neg_res;

  logic               load, last;
  logic [WIDTH-1:0]   in1_neg, in2_neg, mag1, mag2;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   acc_step, b_step;
  logic [2*WIDTH-1:0] prod, prod_neg;

  twos_negate #(.W(WIDTH))   u_neg1 (.din(in1),  .dout(in1_neg));
  twos_negate #(.W(WIDTH))   u_neg2 (.din(in2),  .dout(in2_neg));
  twos_negate #(.W(2*WIDTH)) u_negp (.din(prod), .dout(prod_neg));

  assign mag1 = (sign_mode && in1[WIDTH-1]) ? in1_neg : in1;
  assign mag2 = (sign_mode && in2[WIDTH-1]) ? in2_neg : in2;

  // One iteration: conditional add into the upper half, then shift {carry,acc,b} right.
  assign sum      = b[0] ? ({1'b0, acc} + {1'b0, a}) : {1'b0, acc};
  assign acc_step = sum[WIDTH:1];
  assign b_step   = {sum[0], b[WIDTH-1:1]};
  assign prod     = {acc_step, b_step};

  assign busy = (state == CALC);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = start && (state == IDLE || state == DONE);
    last      = (state == CALC) && (counter == CNT_W'(1));
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath; out is written only on the final iteration so it holds between completions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a       <= '0;
      b       <= '0;
      acc     <= '0;
      counter <= '0;
      neg_res <= 1'b0;
      out     <= '0;
    end else if (load) begin
      a       <= mag1;
      b       <= mag2;
      acc     <= '0;
      counter <= CNT_W'(WIDTH);
      neg_res <= sign_mode & (in1[WIDTH-1] ^ in2[WIDTH-1]);
    end else if (state == CALC) begin
      acc     <= acc_step;
      b       <= b_step;
      counter <= counter - CNT_W'(1);
      if (last) out <= neg_res ? prod_neg : prod;
    end
  end

endmodule
